clint_wide_access_seq: RTL and testbench
========================================

// Module: clint_wide_access_seq
// PURPOSE
//  Sequences 64-bit accesses to the RV32 csr_mem timer block (msip/mtime/mtimecmp) over
//  its 32-bit Wishbone secondary port. A requester (core or debug unit) issues one
//  64-bit read/write; this block issues the ordered 32-bit transactions that make
//  mtime reads rollover-safe and mtime/mtimecmp writes glitch-free. It sits between
//  the requester and csr_mem.
// PARAMETERS
//  MSIP_CODE      2'b00  addr[1:0] of msip in csr_mem
//  MTIME_CODE     2'b10  addr[1:0] of mtime (addr[2]=1 selects high word)
//  MTIMECMP_CODE  2'b11  addr[1:0] of mtimecmp (addr[2]=1 selects high word)
//  ACK_TIMEOUT    16     max cycles stb may wait for ack before abort (>=2)
// PORTS
//  clock      in   1   clock
//  reset      in   1   reset, asynchronous, active-high
//  req_valid  in   1   request present
//  req_ready  out  1   request accepted when req_valid&req_ready at posedge
//  req_we     in   1   1=write, 0=read
//  req_reg    in   2   0=msip, 1=mtime, 2=mtimecmp, 3=illegal
//  req_wdata  in   64  write data (msip uses [31:0])
//  rsp_valid  out  1   one-cycle response pulse
//  rsp_err    out  1   error flag, valid with rsp_valid
//  rsp_rdata  out  64  read data, valid with rsp_valid (0 for writes/errors)
//  wb_cyc     out  1   Wishbone cycle
//  wb_stb     out  1   Wishbone strobe (always equal to wb_cyc)
//  wb_we      out  1   Wishbone write enable
//  wb_addr    out  3   {hi_sel, reg_code}
//  wb_sel     out  4   constant 4'hF
//  wb_dat_o   out  32  write data to csr_mem
//  wb_dat_i   in   32  read data from csr_mem
//  wb_ack     in   1   csr_mem acknowledge
// BEHAVIOUR
//  - Reset: all outputs 0 except req_ready=1 and wb_sel=4'hF; FSM -> IDLE. Reset mid-
//    sequence drops wb_cyc/wb_stb immediately (async), no rsp_valid for the lost request.
//  - FSM: IDLE -> BUS -> GAP -> BUS ... -> RESP -> IDLE. req_ready=1 only in IDLE.
//  - BUS: cyc=stb=1 with addr/we/dat_o held stable until wb_ack sampled high; wb_dat_i
//    captured on that edge. GAP: cyc=stb=0 for exactly one cycle between transactions.
//    Last ack -> RESP (rsp_valid=1 one cycle) -> IDLE.
//  - With a 1-cycle-ack slave an N-transaction op gives rsp_valid 3N cycles after accept.
//  - Sequences (L=low word addr[2]=0, H=high word addr[2]=1):
//    msip rd: rd MSIP -> rdata={32'b0,d}. msip wr: wr MSIP=wdata[31:0].
//    mtime rd: rd H (h1), rd L (lo), rd H (h2); h1==h2 -> {h1,lo}; else rd L again
//      (lo2) -> {h2,lo2} (4 transactions, no further retry).
//    mtime wr: wr L=0, wr H=wdata[63:32], wr L=wdata[31:0].
//    mtimecmp rd: rd L, rd H -> {hi,lo}.
//    mtimecmp wr: wr L=32'hFFFF_FFFF, wr H=wdata[63:32], wr L=wdata[31:0].
//  - req_reg=3: accepted, no bus traffic, rsp_valid+rsp_err one cycle later, rdata=0.
//  - Timeout: counter cleared on BUS entry; if ACK_TIMEOUT cycles elapse in BUS without
//    ack, drop cyc/stb, skip remaining transactions, RESP with rsp_err=1, rdata=0.
//  - rsp_rdata/rsp_err registered, held until next RESP; req_* sampled only on accept.
//  - New req_valid during an op is ignored (req_ready=0); accepted only back in IDLE.
// TESTING
//  - msip wr wdata=64'h0_0000_0001, 1-cycle-ack slave -> one wr addr={0,MSIP_CODE},
//    rsp_valid 3 cycles after accept, rsp_err=0, msip=1.
//  - mtime rd, slave mtime=64'h1_FFFF_FFFF ticks between first H and L -> h1=1,lo=0,
//    h2=2, extra L read -> rsp_rdata=64'h2_0000_0000, 4 transactions, latency 12.
//  - mtimecmp wr 64'h0000_0005_0000_0010 -> wr L=FFFF_FFFF, H=5, L=10 in order, one gap
//    cycle between each; final mtimecmp=64'h5_0000_0010; rsp at 9 cycles.
//  - req_reg=3 -> no wb_cyc, rsp_valid+rsp_err next cycle, rsp_rdata=0.
//  - Slave never acks, ACK_TIMEOUT=16 -> stb low after 16 cycles, rsp_err=1, req_ready=1.
//  - Assert reset during 2nd mtime-write transaction -> cyc/stb 0 same cycle, no rsp_valid,
//    next request after reset completes normally.

Source files
------------

// File: rtl/clint_wide_access_seq.sv
// Turns one 64-bit timer-register request into the ordered 32-bit Wishbone
// transactions that keep mtime reads consistent and mtime/mtimecmp writes glitch-free.
module clint_wide_access_seq #(
  parameter logic [1:0]  MSIP_CODE     = 2'b00,
  parameter logic [1:0]  MTIME_CODE    = 2'b10,
  parameter logic [1:0]  MTIMECMP_CODE = 2'b11,
  parameter int unsigned ACK_TIMEOUT   = 16
) (
  input  logic        clock,
  input  logic        reset,
  // Request/response: a request transfers on a rising edge where req_valid && req_ready;
  // req_* are sampled only then. rsp_valid is a one-cycle pulse with rsp_err/rsp_rdata,
  // which stay held until the next response.
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_reg,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [63:0] rsp_rdata,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [2:0]  wb_addr,
  output logic [3:0]  wb_sel,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack,
  output logic [1:0]  dbg_state_o
);

  localparam int unsigned   TW       = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

  localparam logic [1:0] REG_MSIP     = 2'd0;
  localparam logic [1:0] REG_MTIME    = 2'd1;
  localparam logic [1:0] REG_MTIMECMP = 2'd2;
  localparam logic [1:0] REG_ILLEGAL  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_GAP  = 2'd2,
    S_RESP = 2'd3
  } state_e;

  typedef struct packed {
    logic        we;
    logic [2:0]  addr;
    logic [31:0] dat;
  } txn_t;

  state_e        state_q;
  logic          req_ready_q;
  logic          rsp_valid_q;
  logic          rsp_err_q;
  logic [63:0]   rsp_rdata_q;
  logic          wb_cyc_q;
  logic          wb_we_q;
  logic [2:0]    wb_addr_q;
  logic [31:0]   wb_dat_q;
  logic [1:0]    op_reg_q;
  logic          op_we_q;
  logic [63:0]   wdata_q;
  logic [1:0]    step_q;
  logic [31:0]   hi_q;
  logic [31:0]   lo_q;
  logic [TW-1:0] tmo_q;

  txn_t        first_txn;
  txn_t        next_txn;
  logic        last_c;
  logic        cap_hi_c;
  logic [31:0] hi_d;
  logic [31:0] lo_d;

  // Transaction table: mtime reads go H, L, H (, L); wide writes go L-park, H, L.
  function automatic txn_t txn_f(input logic [1:0] r, input logic we,
                                 input logic [1:0] step, input logic [63:0] wd);
    txn_t       t;
    logic       hi;
    logic [1:0] code;
    hi    = 1'b0;
    t.we  = we;
    t.dat = '0;
    case (r)
      REG_MTIME:    code = MTIME_CODE;
      REG_MTIMECMP: code = MTIMECMP_CODE;
      default:      code = MSIP_CODE;
    endcase
    if (!we) begin
      hi = ((r == REG_MTIME) && ((step == 2'd0) || (step == 2'd2))) ||
           ((r == REG_MTIMECMP) && (step == 2'd1));
    end else if (r == REG_MSIP) begin
      t.dat = wd[31:0];
    end else begin
      case (step)
        2'd0:    t.dat = (r == REG_MTIME) ? 32'h0000_0000 : 32'hFFFF_FFFF;
        2'd1: begin
          hi    = 1'b1;
          t.dat = wd[63:32];
        end
        default: t.dat = wd[31:0];
      endcase
    end
    t.addr = {hi, code};
    return t;
  endfunction

  always_comb begin
    first_txn = txn_f(req_reg, req_we, 2'd0, req_wdata);
    next_txn  = txn_f(op_reg_q, op_we_q, step_q, wdata_q);
  end

  always_comb begin
    last_c   = 1'b0;
    cap_hi_c = 1'b0;
    case (op_reg_q)
      REG_MSIP: last_c = 1'b1;
      REG_MTIME: begin
        if (op_we_q) begin
          last_c = (step_q == 2'd2);
        end else begin
          cap_hi_c = (step_q == 2'd0) || (step_q == 2'd2);
          // Second high read matching the first means the low word was not torn.
          last_c   = (step_q == 2'd3) || ((step_q == 2'd2) && (wb_dat_i == hi_q));
        end
      end
      REG_MTIMECMP: begin
        last_c   = op_we_q ? (step_q == 2'd2) : (step_q == 2'd1);
        cap_hi_c = !op_we_q && (step_q == 2'd1);
      end
      default: last_c = 1'b1;
    endcase
    hi_d = hi_q;
    lo_d = lo_q;
    if (!op_we_q) begin
      if (cap_hi_c) hi_d = wb_dat_i;
      else          lo_d = wb_dat_i;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      wb_cyc_q    <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_addr_q   <= '0;
      wb_dat_q    <= '0;
      op_reg_q    <= '0;
      op_we_q     <= 1'b0;
      wdata_q     <= '0;
      step_q      <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      tmo_q       <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            req_ready_q <= 1'b0;
            op_reg_q    <= req_reg;
            op_we_q     <= req_we;
            wdata_q     <= req_wdata;
            step_q      <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            if (req_reg == REG_ILLEGAL) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              state_q   <= S_BUS;
              wb_cyc_q  <= 1'b1;
              wb_we_q   <= first_txn.we;
              wb_addr_q <= first_txn.addr;
              wb_dat_q  <= first_txn.dat;
              tmo_q     <= '0;
            end
          end
        end
        S_BUS: begin
          if (wb_ack) begin
            wb_cyc_q <= 1'b0;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            if (last_c) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b0;
              rsp_rdata_q <= op_we_q ? 64'd0 : {hi_d, lo_d};
            end else begin
              state_q <= S_GAP;
              step_q  <= step_q + 2'd1;
            end
          end else if (tmo_q == TMO_LAST) begin
            wb_cyc_q    <= 1'b0;
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_GAP: begin
          state_q   <= S_BUS;
          wb_cyc_q  <= 1'b1;
          wb_we_q   <= next_txn.we;
          wb_addr_q <= next_txn.addr;
          wb_dat_q  <= next_txn.dat;
          tmo_q     <= '0;
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign wb_cyc      = wb_cyc_q;
  assign wb_stb      = wb_cyc_q;
  assign wb_we       = wb_we_q;
  assign wb_addr     = wb_addr_q;
  assign wb_sel      = 4'hF;
  assign wb_dat_o    = wb_dat_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_clint_wide_access_seq.sv
// Bench for clint_wide_access_seq: a csr_mem-like timer slave, a value-level model of
// the timer registers, and a response scoreboard fed at issue time.
module tb_clint_wide_access_seq;
  localparam int W = 65;
  localparam int ACK_TIMEOUT = 16;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_reg = 2'd0;
  logic [63:0] req_wdata = '0;
  logic        rsp_valid, rsp_err;
  logic [63:0] rsp_rdata;
  logic        wb_cyc, wb_stb, wb_we;
  logic [2:0]  wb_addr;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dat_o, wb_dat_i;
  logic        wb_ack;
  logic [1:0]  dbg_state;

  clint_wide_access_seq #(.ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_reg(req_reg), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_sel(wb_sel), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack(wb_ack),
    .dbg_state_o(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  int cyc_cnt = 0;
  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // timer slave: registered ack one cycle after strobe, optional tick after an mtime-H read
  logic [31:0] s_msip = '0;
  logic [63:0] s_mtime = '0, s_cmp = '0;
  logic        ack_r;
  logic        no_ack = 1'b0;
  logic        pre_en = 1'b0;
  logic [31:0] pre_msip = '0;
  logic [63:0] pre_mtime = '0, pre_cmp = '0;
  int          tick_req = 0, tick_srv = 0;
  logic [35:0] log_m [0:255];
  int          log_n = 0;

  always_comb begin
    case (wb_addr)
      3'b000:  wb_dat_i = s_msip;
      3'b010:  wb_dat_i = s_mtime[31:0];
      3'b110:  wb_dat_i = s_mtime[63:32];
      3'b011:  wb_dat_i = s_cmp[31:0];
      3'b111:  wb_dat_i = s_cmp[63:32];
      default: wb_dat_i = '0;
    endcase
  end
  assign wb_ack = ack_r;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      ack_r <= 1'b0;
    end else begin
      ack_r <= wb_cyc && wb_stb && !ack_r && !no_ack;
      if (pre_en) begin
        s_msip  <= pre_msip;
        s_mtime <= pre_mtime;
        s_cmp   <= pre_cmp;
      end else if (wb_cyc && wb_stb && ack_r) begin
        log_m[log_n % 256] <= {wb_we, wb_addr, wb_dat_o};
        log_n <= log_n + 1;
        if (wb_we) begin
          case (wb_addr)
            3'b000: s_msip <= wb_dat_o;
            3'b010: s_mtime[31:0] <= wb_dat_o;
            3'b110: s_mtime[63:32] <= wb_dat_o;
            3'b011: s_cmp[31:0] <= wb_dat_o;
            3'b111: s_cmp[63:32] <= wb_dat_o;
            default: ;
          endcase
        end else if (wb_addr == 3'b110 && tick_req != tick_srv) begin
          s_mtime  <= s_mtime + 64'd1;
          tick_srv <= tick_req;
        end
      end
    end
  end

  // monitor / scoreboard
  int          rsp_cnt = 0, rsp_lat = 0, accept_cyc = 0, stb_hi = 0;
  logic        prev_cyc = 1'b0;
  logic [35:0] bus_sig = '0;

  always @(negedge clock) begin
    logic [W-1:0] e;
    if (wb_stb) stb_hi++;
    if (wb_cyc && !prev_cyc) bus_sig = {wb_we, wb_addr, wb_dat_o};
    if (wb_cyc && wb_ack) begin
      chk("bus_stable", 64'({wb_we, wb_addr, wb_dat_o}), 64'(bus_sig));
      chk("stb_eq_cyc", 64'(wb_stb), 64'(wb_cyc));
      chk("wb_sel", 64'(wb_sel), 64'hF);
    end
    prev_cyc = wb_cyc;
    if (rsp_valid) begin
      rsp_lat = cyc_cnt + 1 - accept_cyc;
      rsp_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response");
      end else begin
        e = exp_q.pop_front();
        chk("rsp_err", 64'(rsp_err), 64'(e[64]));
        chk("rsp_rdata", rsp_rdata, e[63:0]);
      end
    end
  end

  // reference model of the timer registers, plus driver tasks
  logic [31:0] m_msip = '0;
  logic [63:0] m_mtime = '0, m_cmp = '0;
  int exp_txn = 0, exp_lat = 0, log_start = 0, rsp_base = 0, stb_base = 0;

  task automatic preload(input logic [31:0] ms, input logic [63:0] mt, input logic [63:0] mc);
    @(negedge clock);
    pre_msip = ms; pre_mtime = mt; pre_cmp = mc; pre_en = 1'b1;
    @(negedge clock);
    pre_en = 1'b0;
    m_msip = ms; m_mtime = mt; m_cmp = mc;
  endtask

  task automatic issue(input logic we, input logic [1:0] r, input logic [63:0] wd,
                       input bit tick, input bit tmo);
    logic        err;
    logic [63:0] d;
    int          ntx;
    int          n;
    err = 1'b0; d = '0; ntx = 0;
    if (tmo) begin
      err = 1'b1;
    end else begin
      case (r)
        2'd0: begin ntx = 1; if (we) m_msip = wd[31:0]; else d = {32'd0, m_msip}; end
        2'd1: begin
          ntx = 3;
          if (we) m_mtime = wd;
          else begin
            if (tick) begin
              if (m_mtime[31:0] == 32'hFFFF_FFFF) ntx = 4;
              m_mtime = m_mtime + 64'd1;
            end
            d = m_mtime;
          end
        end
        2'd2: begin ntx = we ? 3 : 2; if (we) m_cmp = wd; else d = m_cmp; end
        default: err = 1'b1;
      endcase
    end
    exp_txn = ntx;
    exp_lat = tmo ? ACK_TIMEOUT + 1 : ((r == 2'd3) ? 1 : 3 * ntx);
    exp_q.push_back({err, d});
    if (tick) tick_req++;
    log_start = log_n; rsp_base = rsp_cnt; stb_base = stb_hi;
    @(negedge clock);
    req_valid = 1'b1; req_we = we; req_reg = r; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 200) begin @(negedge clock); n++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: req_ready=0 expected 1");
    end
    @(posedge clock);
    #1;
    accept_cyc = cyc_cnt;
    req_valid = 1'b0;
    req_wdata = $urandom;
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (rsp_cnt == rsp_base && n < 300) begin @(negedge clock); n++; end
    chk("rsp_seen", 64'(rsp_cnt - rsp_base), 64'd1);
  endtask

  task automatic run_op(input logic we, input logic [1:0] r, input logic [63:0] wd,
                        input bit tick, input bit tmo);
    issue(we, r, wd, tick, tmo);
    wait_rsp();
    chk("latency", 64'(rsp_lat), 64'(exp_lat));
    chk("txn_count", 64'(log_n - log_start), 64'(exp_txn));
    chk("msip_reg", 64'(s_msip), 64'(m_msip));
    chk("mtime_reg", s_mtime, m_mtime);
    chk("mtimecmp_reg", s_cmp, m_cmp);
  endtask

  task automatic chk_log(input int k, input logic [35:0] e);
    chk($sformatf("bus_txn%0d", k), 64'(log_m[(log_start + k) % 256]), 64'(e));
  endtask

  initial begin
    logic [63:0] old;
    logic [1:0]  r;
    logic        we;
    bit          tick;
    int          n;
    repeat (3) @(negedge clock);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_rsp_rdata", rsp_rdata, 64'd0);
    chk("rst_wb_cyc", 64'(wb_cyc), 64'd0);
    chk("rst_wb_stb", 64'(wb_stb), 64'd0);
    chk("rst_wb_we", 64'(wb_we), 64'd0);
    chk("rst_wb_addr", 64'(wb_addr), 64'd0);
    chk("rst_wb_dat_o", 64'(wb_dat_o), 64'd0);
    chk("rst_wb_sel", 64'(wb_sel), 64'hF);
    reset = 1'b0;
    preload(32'd0, 64'd0, 64'd0);

    run_op(1'b1, 2'd0, 64'h0_0000_0001, 0, 0);
    chk_log(0, {1'b1, 3'b000, 32'h1});

    preload(32'd1, 64'h1_FFFF_FFFF, 64'd0);
    run_op(1'b0, 2'd1, 64'd0, 1, 0);
    chk_log(0, {1'b0, 3'b110, 32'h0});
    chk_log(1, {1'b0, 3'b010, 32'h0});
    chk_log(2, {1'b0, 3'b110, 32'h0});
    chk_log(3, {1'b0, 3'b010, 32'h0});

    run_op(1'b1, 2'd2, 64'h0000_0005_0000_0010, 0, 0);
    chk_log(0, {1'b1, 3'b011, 32'hFFFF_FFFF});
    chk_log(1, {1'b1, 3'b111, 32'h5});
    chk_log(2, {1'b1, 3'b011, 32'h10});

    run_op(1'b0, 2'd3, 64'hDEAD_BEEF_0000_0001, 0, 0);

    no_ack = 1'b1;
    run_op(1'b0, 2'd0, 64'd0, 0, 1);
    chk("tmo_stb_cycles", 64'(stb_hi - stb_base), 64'(ACK_TIMEOUT));
    @(negedge clock);
    chk("tmo_req_ready", 64'(req_ready), 64'd1);
    no_ack = 1'b0;

    // reset in the middle of the second mtime write transaction
    old = m_mtime;
    issue(1'b1, 2'd1, 64'hAAAA_BBBB_CCCC_DDDD, 0, 0);
    n = 0;
    while (!(log_n == log_start + 1 && wb_cyc) && n < 50) begin @(negedge clock); n++; end
    chk("rst_mid_reached", 64'(log_n - log_start), 64'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_cyc", 64'(wb_cyc), 64'd0);
    chk("rst_mid_stb", 64'(wb_stb), 64'd0);
    chk("rst_mid_ready", 64'(req_ready), 64'd1);
    exp_q.delete();
    m_mtime = {old[63:32], 32'h0};
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    chk("rst_mid_no_rsp", 64'(rsp_cnt - rsp_base), 64'd0);
    run_op(1'b0, 2'd1, 64'd0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      r    = 2'($urandom_range(0, 3));
      we   = 1'($urandom_range(0, 1));
      tick = (r == 2'd1 && !we) ? bit'($urandom_range(0, 1)) : 1'b0;
      run_op(we, r, {32'($urandom), ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom)},
             tick, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
